lru_grant_collector: RTL and testbench
======================================

// Module: lru_grant_collector
// PURPOSE
// - Downstream consumer of the LRU matrix arbiter. It presents per-source valid
//   requests to the arbiter as arb_req and takes back the one-hot arb_gnt.
// - Acks the winning source and captures its payload plus source index into a
//   2-entry output FIFO with valid/ready handshake.
// - Checks grant legality and flags starved sources.
// PARAMETERS
// - NUM_REQ      10   number of requesting sources; must match the arbiter
// - DATA_W       32   payload width per source
// - STARVE_LIMIT 64   cycles a source may wait while FIFO has space before flagging
// PORTS
// - clk        in   1                clock, rising edge
// - rst_b      in   1                async reset, active-low
// - src_vld    in   NUM_REQ          per-source request valid
// - src_data   in   NUM_REQ*DATA_W   per-source payload; source i at [i*DATA_W +: DATA_W]
// - src_rdy    out  NUM_REQ          per-source accept, one-hot or zero
// - arb_req    out  NUM_REQ          request vector driven to the arbiter
// - arb_gnt    in   NUM_REQ          grant vector returned by the arbiter (combinational from arb_req)
// - out_vld    out  1                FIFO head valid
// - out_data   out  DATA_W           FIFO head payload
// - out_src    out  $clog2(NUM_REQ)  FIFO head source index
// - out_rdy    in   1                downstream accept
// - gnt_err    out  1                sticky: illegal grant seen
// - starve     out  NUM_REQ          sticky per-source starvation flags
// BEHAVIOUR
// - Reset (rst_b=0, async): FIFO empty (out_vld=0); out_data=0; out_src=0;
//   gnt_err=0; starve=0; all wait counters=0. Reset mid-transfer discards FIFO
//   contents with no further handshake.
// - Definitions: space = (count<2) | (out_vld & out_rdy), i.e. a same-cycle pop
//   frees a slot. Gating arb_req by space is required so that arb_gnt is forced
//   to 0 when no slot is available.
// - Combinational outputs:
//   - arb_req = src_vld & {NUM_REQ{space}}.
//   - legal = arb_gnt is one-hot AND (arb_gnt & ~arb_req) == 0.
//   - src_rdy = arb_gnt when legal, else 0.
// - Transfer: push = |src_rdy. Source i with src_vld & src_rdy has completed its
//   handshake this cycle.
// - Capture: on push, src_data[i] and i are written to the FIFO tail at the
//   clock edge. out_vld rises the next cycle: 1-cycle latency from accept to
//   output.
// - FIFO:
//   - 2 entries, in-order; head visible on out_*.
//   - Pop when out_vld & out_rdy.
//   - Simultaneous push and pop: count unchanged, order preserved.
//   - Push when count==2 cannot occur, because space gates arb_req.
//   - out_data and out_src hold stable while out_vld & ~out_rdy.
// - Illegal grant (|arb_gnt and not legal): no src_rdy, no push, gnt_err<=1.
//   gnt_err stays 1 until reset. Zero grant while arb_req!=0 is not an error:
//   nothing happens that cycle.
// - Starvation, per source i:
//   - Counter wait[i] (width $clog2(STARVE_LIMIT+1)).
//   - Clears when src_rdy[i]=1 or src_vld[i]=0.
//   - Increments when src_vld[i] & ~src_rdy[i] & space, saturating at STARVE_LIMIT.
//   - Holds when ~space (backpressure is not starvation).
//   - When wait[i] reaches STARVE_LIMIT, starve[i]<=1 (sticky until reset).
// - Source rule: src_data must be stable while src_vld=1 and src_rdy=0.
//   A source may not drop src_vld before src_rdy (not checked).
// TESTING
// - Single source: src_vld=0x004, data 0xA5A5A5A5, out_rdy=1, arbiter grants bit 2
//   -> src_rdy=0x004 same cycle; next cycle out_vld=1, out_data=0xA5A5A5A5, out_src=2.
// - Backpressure: out_rdy=0, three sources valid -> two pushes, then arb_req=0 and
//   src_rdy=0. Raise out_rdy -> entries drain in grant order, third source accepted
//   the cycle of the first pop.
// - Simultaneous push/pop with count=1 and out_rdy=1 over 20 cycles, all 10 sources
//   valid -> one transfer per cycle, LRU rotation visible on out_src, no loss or
//   duplication.
// - Illegal grant: force arb_gnt=0x003 -> src_rdy=0, no FIFO write, gnt_err=1 next
//   cycle and held. Also force arb_gnt=0x100 with arb_req=0x001 -> gnt_err=1.
// - Starvation: STARVE_LIMIT=4, hold src_vld[5]=1 with arbiter stubbed never to grant
//   bit 5, FIFO space available -> starve[5]=1 after 4 waiting cycles. Same stimulus
//   with out_rdy=0 and FIFO full -> starve stays 0.
// - Reset mid-operation: FIFO holding 2 entries, assert rst_b=0 asynchronously
//   -> out_vld=0, starve=0, gnt_err=0 immediately; normal operation after release.

Source files
------------

// File: rtl/lru_grant_collector_if.sv
// Bundle between the request sources, the LRU matrix arbiter and the grant collector.
// The master side is the environment (sources, arbiter, sink); the collector is the slave.
interface lru_grant_collector_if #(
   parameter int unsigned NUM_REQ = 10,
   parameter int unsigned DATA_W  = 32
);
   localparam int unsigned SRC_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [NUM_REQ-1:0]        src_vld;
   logic [NUM_REQ*DATA_W-1:0] src_data;
   logic [NUM_REQ-1:0]        src_rdy;
   logic [NUM_REQ-1:0]        arb_req;
   logic [NUM_REQ-1:0]        arb_gnt;
   logic                      out_vld;
   logic [DATA_W-1:0]         out_data;
   logic [SRC_W-1:0]          out_src;
   logic                      out_rdy;
   logic                      gnt_err;
   logic [NUM_REQ-1:0]        starve;

   modport master (
      output src_vld, src_data, arb_gnt, out_rdy,
      input  src_rdy, arb_req, out_vld, out_data, out_src, gnt_err, starve
   );

   modport slave (
      input  src_vld, src_data, arb_gnt, out_rdy,
      output src_rdy, arb_req, out_vld, out_data, out_src, gnt_err, starve
   );
endinterface

// File: rtl/lru_grant_collector.sv
// Collects the arbiter's winner into a 2-entry output FIFO, checks grant legality and
// flags sources that wait too long while the FIFO could have accepted them.
module lru_grant_collector #(
   parameter int unsigned NUM_REQ      = 10,
   parameter int unsigned DATA_W       = 32,
   parameter int unsigned STARVE_LIMIT = 64
) (
   input logic                  clk,
   input logic                  rst_b,
   lru_grant_collector_if.slave bus
);
   localparam int unsigned SRC_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int unsigned WAIT_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(STARVE_LIMIT);

   logic [1:0]         count_q, count_d;
   logic [DATA_W-1:0]  data_q [2];
   logic [DATA_W-1:0]  data_d [2];
   logic [SRC_W-1:0]   src_q [2];
   logic [SRC_W-1:0]   src_d [2];
   logic               gnt_err_q, gnt_err_d;
   logic [NUM_REQ-1:0] starve_q, starve_d;
   logic [WAIT_W-1:0]  wait_cnt_q [NUM_REQ];
   logic [WAIT_W-1:0]  wait_cnt_d [NUM_REQ];

   logic               pop, push, space, any_gnt, legal;
   logic [NUM_REQ-1:0] src_rdy;
   logic [SRC_W-1:0]   push_src;
   logic [DATA_W-1:0]  push_data;

   // A same-cycle pop frees a slot, so full-rate streaming is possible at count==1 or 2.
   assign pop     = (count_q != 2'd0) & bus.out_rdy;
   assign space   = (count_q != 2'd2) | pop;
   assign any_gnt = |bus.arb_gnt;
   assign legal   = any_gnt
                    && ((bus.arb_gnt & (bus.arb_gnt - NUM_REQ'(1))) == '0)
                    && ((bus.arb_gnt & ~bus.arb_req) == '0);
   assign src_rdy = legal ? bus.arb_gnt : '0;
   assign push    = |src_rdy;

   assign bus.arb_req  = bus.src_vld & {NUM_REQ{space}};
   assign bus.src_rdy  = src_rdy;
   assign bus.out_vld  = (count_q != 2'd0);
   assign bus.out_data = data_q[0];
   assign bus.out_src  = src_q[0];
   assign bus.gnt_err  = gnt_err_q;
   assign bus.starve   = starve_q;

   always_comb begin
      push_src  = '0;
      push_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (src_rdy[i]) begin
            push_src  = SRC_W'(i);
            push_data = bus.src_data[i*DATA_W +: DATA_W];
         end
      end
   end

   // Entry 0 is always the head; entry 1 shifts down on pop.
   always_comb begin
      count_d = count_q;
      data_d  = data_q;
      src_d   = src_q;
      unique case ({push, pop})
         2'b10: begin
            if (count_q == 2'd0) begin
               data_d[0] = push_data;
               src_d[0]  = push_src;
            end else begin
               data_d[1] = push_data;
               src_d[1]  = push_src;
            end
            count_d = count_q + 2'd1;
         end
         2'b01: begin
            data_d[0] = data_q[1];
            src_d[0]  = src_q[1];
            count_d   = count_q - 2'd1;
         end
         2'b11: begin
            if (count_q == 2'd1) begin
               data_d[0] = push_data;
               src_d[0]  = push_src;
            end else begin
               data_d[0] = data_q[1];
               src_d[0]  = src_q[1];
               data_d[1] = push_data;
               src_d[1]  = push_src;
            end
         end
         default: ;
      endcase
   end

   // Waiting only counts while the FIFO could have taken the request.
   always_comb begin
      gnt_err_d = gnt_err_q | (any_gnt & ~legal);
      for (int i = 0; i < NUM_REQ; i++) begin
         wait_cnt_d[i] = wait_cnt_q[i];
         if (src_rdy[i] || !bus.src_vld[i]) begin
            wait_cnt_d[i] = '0;
         end else if (space && (wait_cnt_q[i] != WAIT_MAX)) begin
            wait_cnt_d[i] = wait_cnt_q[i] + WAIT_W'(1);
         end
         starve_d[i] = starve_q[i] | (wait_cnt_d[i] == WAIT_MAX);
      end
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         count_q   <= '0;
         gnt_err_q <= 1'b0;
         starve_q  <= '0;
         for (int e = 0; e < 2; e++) begin
            data_q[e] <= '0;
            src_q[e]  <= '0;
         end
         for (int i = 0; i < NUM_REQ; i++) begin
            wait_cnt_q[i] <= '0;
         end
      end else begin
         count_q    <= count_d;
         data_q     <= data_d;
         src_q      <= src_d;
         gnt_err_q  <= gnt_err_d;
         starve_q   <= starve_d;
         wait_cnt_q <= wait_cnt_d;
      end
   end
endmodule

// File: tb/tb_lru_grant_collector.sv
// Randomised and directed bench for lru_grant_collector with an LRU arbiter stand-in and a
// queue-based model of the accept/FIFO/error/starvation rules.
module tb_lru_grant_collector;
   localparam int unsigned N   = 10;
   localparam int unsigned DW  = 32;
   localparam int unsigned LIM = 4;

   typedef struct packed {
      logic [3:0]    src;
      logic [DW-1:0] data;
   } entry_t;

   logic clk   = 1'b0;
   logic rst_b = 1'b1;
   always #5 clk = ~clk;

   lru_grant_collector_if #(.NUM_REQ(N), .DATA_W(DW)) bus ();

   lru_grant_collector #(.NUM_REQ(N), .DATA_W(DW), .STARVE_LIMIT(LIM)) dut (
      .clk   (clk),
      .rst_b (rst_b),
      .bus   (bus)
   );

   // Arbiter stand-in: least recently granted first, optionally overridden or masked.
   logic             force_en;
   logic [N-1:0]     force_val;
   logic [N-1:0]     block_mask;
   logic [N-1:0][3:0] lru_order;

   entry_t        exp_q[$];
   logic          exp_err;
   logic [N-1:0]  exp_starve;
   int            exp_wait [N];
   logic          m_space;
   logic [N-1:0]  m_req, m_gnt, m_rdy;
   int            checks = 0;
   int            errors = 0;

   function automatic logic [N-1:0] lru_pick(input logic [N-1:0] req,
                                             input logic [N-1:0][3:0] ord);
      logic [N-1:0] g;
      g = '0;
      for (int k = 0; k < N; k++) begin
         if (g == '0 && req[ord[k]]) g[ord[k]] = 1'b1;
      end
      return g;
   endfunction

   always_comb bus.arb_gnt = force_en ? force_val : lru_pick(bus.arb_req & ~block_mask, lru_order);

   function automatic void model_eval();
      m_space = (exp_q.size() < 2) || (exp_q.size() > 0 && bus.out_rdy);
      m_req   = bus.src_vld & {N{m_space}};
      m_gnt   = force_en ? force_val : lru_pick(m_req & ~block_mask, lru_order);
      m_rdy   = ($countones(m_gnt) == 1 && (m_gnt & ~m_req) == '0) ? m_gnt : '0;
   endfunction

   always @(posedge clk) begin : upd
      logic [N-1:0][3:0] nord;
      int w, p;
      if (!rst_b) begin
         for (int k = 0; k < N; k++) nord[k] = 4'(k);
         lru_order <= nord;
      end else begin
         model_eval();
         if (exp_q.size() > 0 && bus.out_rdy) void'(exp_q.pop_front());
         if (m_gnt != '0 && m_rdy == '0) exp_err = 1'b1;
         w = -1;
         for (int i = 0; i < N; i++) begin
            if (m_rdy[i]) begin
               exp_q.push_back('{src: 4'(i), data: bus.src_data[i*DW +: DW]});
               w = i;
            end
            if (m_rdy[i] || !bus.src_vld[i]) exp_wait[i] = 0;
            else if (m_space && exp_wait[i] < int'(LIM)) exp_wait[i]++;
            if (exp_wait[i] == int'(LIM)) exp_starve[i] = 1'b1;
         end
         if (w >= 0) begin
            nord = lru_order;
            p = 0;
            for (int k = 0; k < N; k++) if (nord[k] == 4'(w)) p = k;
            for (int k = p; k < N - 1; k++) nord[k] = nord[k+1];
            nord[N-1] = 4'(w);
            lru_order <= nord;
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic model_clear();
      exp_q.delete();
      exp_err    = 1'b0;
      exp_starve = '0;
      foreach (exp_wait[i]) exp_wait[i] = 0;
   endtask

   task automatic apply_reset();
      rst_b = 1'b0;
      model_clear();
      repeat (2) cyc();
      rst_b = 1'b1;
   endtask

   // Accepted or idle sources may present fresh requests; waiting ones hold their data.
   task automatic drive_sources(input logic [N-1:0] acc, input int unsigned pct);
      for (int i = 0; i < N; i++) begin
         if (acc[i] || !bus.src_vld[i]) begin
            bus.src_vld[i]            = ($urandom_range(99) < pct);
            bus.src_data[i*DW +: DW]  = $urandom;
         end
      end
   endtask

   task automatic test_reset();
      rst_b = 1'b0;
      model_clear();
      @(negedge clk);
      checks++; if (bus.out_vld !== 1'b0) begin errors++;
         $display("FAIL reset_out_vld got %b want 0", bus.out_vld); end
      checks++; if (bus.out_data !== 32'h0 || bus.out_src !== 4'h0) begin errors++;
         $display("FAIL reset_out_fields got %h/%0d want 0/0", bus.out_data, bus.out_src); end
      checks++; if (bus.gnt_err !== 1'b0 || bus.starve !== 10'h0) begin errors++;
         $display("FAIL reset_flags got %b/%h want 0/000", bus.gnt_err, bus.starve); end
      checks++; if (bus.arb_req !== 10'h0) begin errors++;
         $display("FAIL reset_arb_req got %h want 000", bus.arb_req); end
      cyc();
      rst_b = 1'b1;
      cyc();
   endtask

   task automatic test_single();
      bus.out_rdy = 1'b1;
      bus.src_vld = 10'h004;
      bus.src_data[2*DW +: DW] = 32'hA5A5A5A5;
      @(negedge clk);
      checks++; if (bus.src_rdy !== 10'h004) begin errors++;
         $display("FAIL single_src_rdy got %h want 004", bus.src_rdy); end
      cyc();
      bus.src_vld = '0;
      @(negedge clk);
      checks++; if (bus.out_vld !== 1'b1) begin errors++;
         $display("FAIL single_out_vld got %b want 1", bus.out_vld); end
      checks++; if (bus.out_data !== 32'hA5A5A5A5 || bus.out_src !== 4'd2) begin errors++;
         $display("FAIL single_out got %h/%0d want a5a5a5a5/2", bus.out_data, bus.out_src); end
      cyc();
   endtask

   task automatic test_backpressure();
      logic [N-1:0] m3, acc;
      m3 = '0;
      while ($countones(m3) < 3) m3[$urandom_range(N-1)] = 1'b1;
      bus.out_rdy = 1'b0;
      bus.src_vld = m3;
      for (int i = 0; i < N; i++) bus.src_data[i*DW +: DW] = $urandom;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         model_eval();
         checks++; if (bus.src_rdy !== m_rdy) begin errors++;
            $display("FAIL bp_src_rdy cyc %0d got %h want %h", c, bus.src_rdy, m_rdy); end
         if (c >= 2) begin
            checks++; if (bus.arb_req !== 10'h0 || bus.src_rdy !== 10'h0) begin errors++;
               $display("FAIL bp_full_gate cyc %0d got %h/%h want 000/000", c, bus.arb_req,
                        bus.src_rdy); end
         end
         acc = m_rdy;
         cyc();
         bus.src_vld = bus.src_vld & ~acc;
      end
      bus.out_rdy = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         model_eval();
         if (c == 0) begin
            checks++; if (bus.src_rdy !== bus.src_vld) begin errors++;
               $display("FAIL bp_third_on_pop got %h want %h", bus.src_rdy, bus.src_vld); end
         end
         checks++; if (bus.out_vld !== (exp_q.size() != 0)) begin errors++;
            $display("FAIL bp_out_vld cyc %0d got %b want %b", c, bus.out_vld, exp_q.size() != 0);
         end
         if (exp_q.size() != 0) begin
            checks++;
            if (bus.out_src !== exp_q[0].src || bus.out_data !== exp_q[0].data) begin errors++;
               $display("FAIL bp_drain cyc %0d got %0d/%h want %0d/%h", c, bus.out_src,
                        bus.out_data, exp_q[0].src, exp_q[0].data); end
         end
         acc = m_rdy;
         cyc();
         bus.src_vld = bus.src_vld & ~acc;
      end
   endtask

   task automatic test_back_to_back();
      logic [N-1:0] seen, acc;
      int npop;
      seen = '0;
      npop = 0;
      bus.out_rdy = 1'b1;
      bus.src_vld = '1;
      for (int i = 0; i < N; i++) bus.src_data[i*DW +: DW] = $urandom;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         model_eval();
         checks++; if (bus.src_rdy !== m_rdy || $countones(bus.src_rdy) != 1) begin errors++;
            $display("FAIL b2b_src_rdy cyc %0d got %h want %h", c, bus.src_rdy, m_rdy); end
         if (c > 0) begin
            checks++;
            if (exp_q.size() == 0 || bus.out_vld !== 1'b1 || bus.out_src !== exp_q[0].src ||
                bus.out_data !== exp_q[0].data) begin errors++;
               $display("FAIL b2b_head cyc %0d got %b/%0d/%h", c, bus.out_vld, bus.out_src,
                        bus.out_data); end
         end
         if (bus.out_vld === 1'b1 && npop < 10) begin
            seen[bus.out_src] = 1'b1;
            npop++;
         end
         acc = m_rdy;
         cyc();
         for (int i = 0; i < N; i++) if (acc[i]) bus.src_data[i*DW +: DW] = $urandom;
      end
      checks++; if (seen !== 10'h3FF) begin errors++;
         $display("FAIL b2b_lru_rotation got %h want 3ff", seen); end
      bus.src_vld = '0;
      repeat (2) cyc();
   endtask

   task automatic test_illegal();
      apply_reset();
      bus.out_rdy = 1'b1;
      bus.src_vld = 10'h003;
      force_en = 1'b1;
      force_val = 10'h003;
      @(negedge clk);
      checks++; if (bus.src_rdy !== 10'h0) begin errors++;
         $display("FAIL ill_two_hot_rdy got %h want 000", bus.src_rdy); end
      cyc();
      force_en = 1'b0;
      bus.src_vld = '0;
      @(negedge clk);
      checks++; if (bus.gnt_err !== 1'b1 || bus.out_vld !== 1'b0) begin errors++;
         $display("FAIL ill_two_hot_err got %b/%b want 1/0", bus.gnt_err, bus.out_vld); end
      repeat (3) cyc();
      @(negedge clk);
      checks++; if (bus.gnt_err !== 1'b1) begin errors++;
         $display("FAIL ill_sticky got %b want 1", bus.gnt_err); end
      cyc();
      apply_reset();
      bus.src_vld = 10'h001;
      force_en = 1'b1;
      force_val = 10'h000;
      cyc();
      @(negedge clk);
      checks++; if (bus.gnt_err !== 1'b0) begin errors++;
         $display("FAIL ill_zero_gnt got %b want 0", bus.gnt_err); end
      force_val = 10'h100;
      @(negedge clk);
      checks++; if (bus.src_rdy !== 10'h0) begin errors++;
         $display("FAIL ill_unrequested_rdy got %h want 000", bus.src_rdy); end
      cyc();
      force_en = 1'b0;
      bus.src_vld = '0;
      @(negedge clk);
      checks++; if (bus.gnt_err !== 1'b1 || bus.out_vld !== 1'b0) begin errors++;
         $display("FAIL ill_unrequested_err got %b/%b want 1/0", bus.gnt_err, bus.out_vld); end
      cyc();
   endtask

   task automatic test_starve();
      logic [N-1:0] acc;
      apply_reset();
      block_mask = 10'h020;
      bus.out_rdy = 1'b1;
      bus.src_vld = 10'h020;
      for (int k = 1; k <= 6; k++) begin
         cyc();
         @(negedge clk);
         checks++; if (bus.starve !== ((k >= int'(LIM)) ? 10'h020 : 10'h000)) begin errors++;
            $display("FAIL starve_space after %0d waits got %h", k, bus.starve); end
      end
      cyc();
      apply_reset();
      bus.out_rdy = 1'b0;
      bus.src_vld = 10'h003;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         model_eval();
         acc = m_rdy;
         cyc();
         bus.src_vld = bus.src_vld & ~acc;
      end
      bus.src_vld = 10'h020;
      repeat (8) cyc();
      @(negedge clk);
      checks++; if (bus.starve !== 10'h0 || bus.out_vld !== 1'b1) begin errors++;
         $display("FAIL starve_backpressure got %h/%b want 000/1", bus.starve, bus.out_vld); end
      cyc();
      bus.src_vld = '0;
      block_mask = '0;
      bus.out_rdy = 1'b1;
      repeat (3) cyc();
   endtask

   task automatic test_random_traffic();
      logic [N-1:0] acc;
      for (int c = 0; c < 400; c++) begin
         bus.out_rdy = ($urandom_range(99) < 70);
         force_en = ($urandom_range(39) == 0);
         force_val = 10'($urandom);
         @(negedge clk);
         model_eval();
         checks++; if (bus.arb_req !== m_req) begin errors++;
            $display("FAIL rnd_arb_req cyc %0d got %h want %h", c, bus.arb_req, m_req); end
         checks++; if (bus.src_rdy !== m_rdy) begin errors++;
            $display("FAIL rnd_src_rdy cyc %0d got %h want %h", c, bus.src_rdy, m_rdy); end
         checks++; if (bus.out_vld !== (exp_q.size() != 0)) begin errors++;
            $display("FAIL rnd_out_vld cyc %0d got %b", c, bus.out_vld); end
         if (exp_q.size() != 0) begin
            checks++;
            if (bus.out_src !== exp_q[0].src || bus.out_data !== exp_q[0].data) begin errors++;
               $display("FAIL rnd_head cyc %0d got %0d/%h want %0d/%h", c, bus.out_src,
                        bus.out_data, exp_q[0].src, exp_q[0].data); end
         end
         checks++; if (bus.gnt_err !== exp_err || bus.starve !== exp_starve) begin errors++;
            $display("FAIL rnd_flags cyc %0d got %b/%h want %b/%h", c, bus.gnt_err, bus.starve,
                     exp_err, exp_starve); end
         acc = m_rdy;
         cyc();
         drive_sources(acc, 50);
      end
      force_en = 1'b0;
      bus.src_vld = '0;
      bus.out_rdy = 1'b1;
      repeat (3) cyc();
   endtask

   task automatic test_reset_mid();
      logic [N-1:0] acc;
      bus.out_rdy = 1'b0;
      bus.src_vld = 10'h300;
      for (int i = 0; i < N; i++) bus.src_data[i*DW +: DW] = $urandom;
      force_en = 1'b1;
      force_val = 10'h300;
      cyc();
      force_en = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         model_eval();
         acc = m_rdy;
         cyc();
         bus.src_vld = bus.src_vld & ~acc;
      end
      @(negedge clk);
      checks++; if (bus.out_vld !== 1'b1 || bus.gnt_err !== 1'b1) begin errors++;
         $display("FAIL mid_prefill got %b/%b want 1/1", bus.out_vld, bus.gnt_err); end
      #2;
      rst_b = 1'b0;
      model_clear();
      #1;
      checks++; if (bus.out_vld !== 1'b0 || bus.gnt_err !== 1'b0 || bus.starve !== 10'h0)
         begin errors++;
         $display("FAIL mid_async_reset got %b/%b/%h want 0/0/000", bus.out_vld, bus.gnt_err,
                  bus.starve); end
      cyc();
      rst_b = 1'b1;
      bus.out_rdy = 1'b1;
      bus.src_vld = 10'h010;
      bus.src_data[4*DW +: DW] = 32'h1234_5678;
      @(negedge clk);
      checks++; if (bus.src_rdy !== 10'h010) begin errors++;
         $display("FAIL mid_after_rdy got %h want 010", bus.src_rdy); end
      cyc();
      bus.src_vld = '0;
      @(negedge clk);
      checks++; if (bus.out_vld !== 1'b1 || bus.out_src !== 4'd4 || bus.out_data !== 32'h12345678)
         begin errors++;
         $display("FAIL mid_after_out got %b/%0d/%h want 1/4/12345678", bus.out_vld, bus.out_src,
                  bus.out_data); end
      cyc();
   endtask

   initial begin
      force_en     = 1'b0;
      force_val    = '0;
      block_mask   = '0;
      bus.src_vld  = '0;
      bus.src_data = '0;
      bus.out_rdy  = 1'b0;
      model_clear();
      #1;
      test_reset();
      test_single();
      test_backpressure();
      test_back_to_back();
      test_illegal();
      test_starve();
      test_random_traffic();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
